// File: rtl/eth_udp_rx_check.sv
// eth_udp_rx_check: Ethernet II / IPv4 / UDP receive parser and checker.
// Checks FCS, addressing and (with RX_UDP_CSUM_EN) the UDP checksum.
//
// Ports:
//   clk, clear_n        clock, synchronous active-low reset
//   rx_data/valid/first/last  received frame bytes (FCS attached)
//   pl_data/valid/first/last  UDP payload stream, registered
//   frame_done          one-cycle status strobe, 2 cycles after rx_last
//   fcs_ok, hdr_ok, udp_ok, len_err  held status flags
//
// Optional feature macro: RX_UDP_CSUM_EN (UDP checksum check).
// When undefined, udp_ok reads 1 from the first frame_done onwards.

module eth_udp_rx_check #(
    parameter logic [31:0] LOCAL_IP   = 32'hC0A8_002C,
    parameter logic [15:0] LOCAL_PORT = 16'h0400
) (
    input  logic       clk,
    input  logic       clear_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_first,
    input  logic       rx_last,
    output logic [7:0] pl_data,
    output logic       pl_valid,
    output logic       pl_first,
    output logic       pl_last,
    output logic       frame_done,
    output logic       fcs_ok,
    output logic       hdr_ok,
    output logic       udp_ok,
    output logic       len_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_DATA, S_TAIL, S_DROP
    } state_t;

    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

    function automatic logic [31:0] crc_byte(
        input logic [31:0] c,
        input logic [7:0]  b
    );
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        end
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] crc_q, crc_d;
    logic [15:0] ulen_q, ulen_d;
    logic        bad_q, bad_d;
    logic        hok_q, hok_d;
    logic        lerr_q, lerr_d;
    logic [7:0]  pl_data_q, pl_data_d;
    logic        pl_valid_q, pl_valid_d;
    logic        pl_first_q, pl_first_d;
    logic        pl_last_q, pl_last_d;
    // stage 1: snapshot at the end of a frame
    logic        s1_q, s1_d;
    logic [31:0] s1_crc_q, s1_crc_d;
    logic        s1_hok_q, s1_hok_d;
    logic        s1_lerr_q, s1_lerr_d;
    // stage 2: CRC compare and first fold
    logic        s2_q, s2_d;
    logic        s2_fcs_q, s2_fcs_d;
    logic        s2_hok_q, s2_hok_d;
    logic        s2_lerr_q, s2_lerr_d;
    // status outputs
    logic        done_q, done_d;
    logic        fcs_q, fcs_d;
    logic        hdr_q, hdr_d;
    logic        udp_q, udp_d;
    logic        len_q, len_d;

`ifdef RX_UDP_CSUM_EN
    logic [31:0] sum_q, sum_d;
    logic        cz_q, cz_d;
    logic [31:0] s1_sum_q, s1_sum_d;
    logic        s1_cz_q, s1_cz_d;
    logic [16:0] s2_fold_q, s2_fold_d;
    logic        s2_cz_q, s2_cz_d;
    logic [15:0] word;
    logic [15:0] fold2;
`endif

    state_t      cur;
    logic [15:0] off;
    logic [16:0] last_off;
    logic        mis;
    logic        abort;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        crc_d      = crc_q;
        ulen_d     = ulen_q;
        bad_d      = bad_q;
        hok_d      = hok_q;
        lerr_d     = lerr_q;
        pl_data_d  = pl_data_q;
        pl_valid_d = 1'b0;
        pl_first_d = 1'b0;
        pl_last_d  = 1'b0;
        s1_d       = 1'b0;
        s1_crc_d   = s1_crc_q;
        s1_hok_d   = s1_hok_q;
        s1_lerr_d  = s1_lerr_q;
        // a new frame always starts parsing as byte 0 of the header
        cur      = rx_first ? S_HDR : state_q;
        off      = rx_first ? 16'd0 : cnt_q;
        last_off = {1'b0, ulen_q} + 17'd33;
        abort    = rx_valid && rx_first && (state_q != S_IDLE);
`ifdef RX_UDP_CSUM_EN
        sum_d    = sum_q;
        cz_d     = cz_q;
        s1_sum_d = s1_sum_q;
        s1_cz_d  = s1_cz_q;
        // even offsets are the high byte of a 16-bit word
        word     = off[0] ? {8'h00, rx_data} : {rx_data, 8'h00};
`endif

        unique case (off)
            16'd12:  mis = rx_data != 8'h08;
            16'd13:  mis = rx_data != 8'h00;
            16'd14:  mis = rx_data != 8'h45;
            16'd23:  mis = rx_data != 8'h11;
            16'd30:  mis = rx_data != LOCAL_IP[31:24];
            16'd31:  mis = rx_data != LOCAL_IP[23:16];
            16'd32:  mis = rx_data != LOCAL_IP[15:8];
            16'd33:  mis = rx_data != LOCAL_IP[7:0];
            16'd36:  mis = rx_data != LOCAL_PORT[15:8];
            16'd37:  mis = rx_data != LOCAL_PORT[7:0];
            default: mis = 1'b0;
        endcase

        if (rx_valid && cur != S_IDLE) begin
            if (rx_first) begin
                crc_d  = crc_byte(32'hFFFF_FFFF, rx_data);
                cnt_d  = 16'd1;
                ulen_d = 16'd0;
                bad_d  = 1'b0;
                hok_d  = 1'b0;
                lerr_d = 1'b0;
`ifdef RX_UDP_CSUM_EN
                // pseudo-header protocol word
                sum_d  = 32'h0000_0011;
                cz_d   = 1'b0;
`endif
            end else begin
                crc_d = crc_byte(crc_q, rx_data);
                if (cnt_q != 16'hFFFF) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            unique case (cur)
                S_HDR: begin
                    state_d = S_HDR;
                    bad_d   = bad_d | mis;
                    if (off == 16'd38) ulen_d[15:8] = rx_data;
                    if (off == 16'd39) ulen_d[7:0]  = rx_data;
`ifdef RX_UDP_CSUM_EN
                    if (off >= 16'd26) begin
                        sum_d = sum_d + {16'h0, word};
                    end
                    // UDP length also appears in the pseudo-header
                    if (off == 16'd38 || off == 16'd39) begin
                        sum_d = sum_d + {16'h0, word};
                    end
                    if (off == 16'd40) cz_d = (rx_data == 8'h00);
                    if (off == 16'd41) cz_d = cz_q && (rx_data == 8'h00);
`endif
                    if (off == 16'd41) begin
                        hok_d  = !bad_d;
                        lerr_d = ulen_q < 16'd8;
                        if (!hok_d || ulen_q < 16'd8) begin
                            state_d = S_DROP;
                        end else if (ulen_q == 16'd8) begin
                            state_d = S_TAIL;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    pl_valid_d = 1'b1;
                    pl_data_d  = rx_data;
                    pl_first_d = off == 16'd42;
                    pl_last_d  = ({1'b0, off} == last_off) || rx_last;
`ifdef RX_UDP_CSUM_EN
                    sum_d = sum_q + {16'h0, word};
`endif
                    if ({1'b0, off} == last_off) begin
                        state_d = S_TAIL;
                    end
                end
                default: ;
            endcase

            if (rx_last) begin
                state_d   = S_IDLE;
                s1_d      = 1'b1;
                s1_crc_d  = crc_d;
                s1_hok_d  = hok_d;
                s1_lerr_d = lerr_d
                    || cur == S_HDR
                    || cur == S_DATA
                    || off < 16'd63
                    || (cur == S_TAIL
                        && {1'b0, off} < {1'b0, ulen_q} + 17'd37);
`ifdef RX_UDP_CSUM_EN
                s1_sum_d = sum_d;
                s1_cz_d  = cz_d;
`endif
            end
        end

        // missing rx_last: report the old frame from its live state
        if (abort) begin
            s1_d      = 1'b1;
            s1_crc_d  = crc_q;
            s1_hok_d  = hok_q;
            s1_lerr_d = 1'b1;
`ifdef RX_UDP_CSUM_EN
            s1_sum_d = sum_q;
            s1_cz_d  = cz_q;
`endif
        end

        s2_d      = s1_q;
        s2_fcs_d  = s1_crc_q == CRC_RESIDUE;
        s2_hok_d  = s1_hok_q;
        s2_lerr_d = s1_lerr_q;
`ifdef RX_UDP_CSUM_EN
        s2_fold_d = {1'b0, s1_sum_q[31:16]} + {1'b0, s1_sum_q[15:0]};
        s2_cz_d   = s1_cz_q;
        fold2     = s2_fold_q[15:0] + {15'h0, s2_fold_q[16]};
`endif

        done_d = s2_q;
        fcs_d  = fcs_q;
        hdr_d  = hdr_q;
        udp_d  = udp_q;
        len_d  = len_q;
        if (s2_q) begin
            fcs_d = s2_fcs_q;
            hdr_d = s2_hok_q;
            len_d = s2_lerr_q;
`ifdef RX_UDP_CSUM_EN
            udp_d = (fold2 == 16'hFFFF) || s2_cz_q;
`else
            udp_d = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 16'd0;
            crc_q      <= 32'hFFFF_FFFF;
            ulen_q     <= 16'd0;
            bad_q      <= 1'b0;
            hok_q      <= 1'b0;
            lerr_q     <= 1'b0;
            pl_data_q  <= 8'h00;
            pl_valid_q <= 1'b0;
            pl_first_q <= 1'b0;
            pl_last_q  <= 1'b0;
            s1_q       <= 1'b0;
            s1_crc_q   <= 32'h0;
            s1_hok_q   <= 1'b0;
            s1_lerr_q  <= 1'b0;
            s2_q       <= 1'b0;
            s2_fcs_q   <= 1'b0;
            s2_hok_q   <= 1'b0;
            s2_lerr_q  <= 1'b0;
            done_q     <= 1'b0;
            fcs_q      <= 1'b0;
            hdr_q      <= 1'b0;
            udp_q      <= 1'b0;
            len_q      <= 1'b0;
`ifdef RX_UDP_CSUM_EN
            sum_q      <= 32'h0;
            cz_q       <= 1'b0;
            s1_sum_q   <= 32'h0;
            s1_cz_q    <= 1'b0;
            s2_fold_q  <= 17'h0;
            s2_cz_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            crc_q      <= crc_d;
            ulen_q     <= ulen_d;
            bad_q      <= bad_d;
            hok_q      <= hok_d;
            lerr_q     <= lerr_d;
            pl_data_q  <= pl_data_d;
            pl_valid_q <= pl_valid_d;
            pl_first_q <= pl_first_d;
            pl_last_q  <= pl_last_d;
            s1_q       <= s1_d;
            s1_crc_q   <= s1_crc_d;
            s1_hok_q   <= s1_hok_d;
            s1_lerr_q  <= s1_lerr_d;
            s2_q       <= s2_d;
            s2_fcs_q   <= s2_fcs_d;
            s2_hok_q   <= s2_hok_d;
            s2_lerr_q  <= s2_lerr_d;
            done_q     <= done_d;
            fcs_q      <= fcs_d;
            hdr_q      <= hdr_d;
            udp_q      <= udp_d;
            len_q      <= len_d;
`ifdef RX_UDP_CSUM_EN
            sum_q      <= sum_d;
            cz_q       <= cz_d;
            s1_sum_q   <= s1_sum_d;
            s1_cz_q    <= s1_cz_d;
            s2_fold_q  <= s2_fold_d;
            s2_cz_q    <= s2_cz_d;
`endif
        end
    end

    assign pl_data    = pl_data_q;
    assign pl_valid   = pl_valid_q;
    assign pl_first   = pl_first_q;
    assign pl_last    = pl_last_q;
    assign frame_done = done_q;
    assign fcs_ok     = fcs_q;
    assign hdr_ok     = hdr_q;
    assign udp_ok     = udp_q;
    assign len_err    = len_q;

endmodule

// File: tb/tb_eth_udp_rx_check.sv
// Self-checking bench for eth_udp_rx_check.
// Payload beats and status strobes are checked against scoreboard queues.

`timescale 1ns/1ps

module tb_eth_udp_rx_check;

`ifdef RX_UDP_CSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       clear_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_first = 1'b0;
    logic       rx_last = 1'b0;
    logic [7:0] pl_data;
    logic       pl_valid, pl_first, pl_last;
    logic       frame_done, fcs_ok, hdr_ok, udp_ok, len_err;

    always #5 clk = ~clk;

    eth_udp_rx_check dut (
        .clk        (clk),
        .clear_n    (clear_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_first   (rx_first),
        .rx_last    (rx_last),
        .pl_data    (pl_data),
        .pl_valid   (pl_valid),
        .pl_first   (pl_first),
        .pl_last    (pl_last),
        .frame_done (frame_done),
        .fcs_ok     (fcs_ok),
        .hdr_ok     (hdr_ok),
        .udp_ok     (udp_ok),
        .len_err    (len_err)
    );

    typedef struct {
        logic [7:0] d;
        logic       f;
        logic       l;
    } beat_t;

    // flags ordered {fcs, hdr, udp, len_err}; m masks which are checked
    typedef struct {
        logic [3:0] e;
        logic [3:0] m;
        int         due;
    } stat_t;

    beat_t      exp_pl[$];
    stat_t      exp_st[$];
    logic [7:0] frm[$];
    logic [7:0] pay[$];

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int last_cyc = 0;
    int beat_cnt = 0;
    int done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        beat_t eb;
        stat_t es;
        logic [3:0] got;
        if (pl_valid) begin
            beat_cnt++;
            checks++;
            if (exp_pl.size() == 0) begin
                $display("FAIL pl_extra: got beat d=%h, required no beat",
                         pl_data);
            end else begin
                eb = exp_pl.pop_front();
                if ({pl_data, pl_first, pl_last} !== {eb.d, eb.f, eb.l})
                    $display("FAIL pl_beat: got d=%h f=%b l=%b, required d=%h f=%b l=%b",
                             pl_data, pl_first, pl_last, eb.d, eb.f, eb.l);
                else
                    passed++;
            end
        end
        if (frame_done) begin
            done_cnt++;
            checks++;
            got = {fcs_ok, hdr_ok, udp_ok, len_err};
            if (exp_st.size() == 0) begin
                $display("FAIL done_extra: got frame_done flags=%b, required none",
                         got);
            end else begin
                es = exp_st.pop_front();
                if ((got & es.m) !== (es.e & es.m)
                    || (es.due != 0 && cyc != es.due))
                    $display("FAIL status: got flags=%b cyc=%0d, required %b mask %b cyc=%0d",
                             got, cyc, es.e, es.m, es.due);
                else
                    passed++;
            end
        end
    end

    function automatic logic [31:0] crc32(
        input logic [31:0] c,
        input logic [7:0]  b
    );
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    // Builds frm from pay; flip >= 0 xors payload byte flip with 0x01,
    // before (flip_late=0) or after (flip_late=1) the FCS is computed.
    task automatic build(
        input logic [15:0] dport,
        input logic [15:0] ulen,
        input int          pad,
        input bit          zero_cs,
        input int          flip,
        input bit          flip_late,
        input bit          emit
    );
        logic [7:0]  h [42];
        logic [15:0] tl;
        logic [31:0] s;
        logic [31:0] c;
        logic [15:0] cs;
        int          n;
        tl = ulen + 16'd20;
        s  = 32'hC0A8 + 32'h0001 + 32'hC0A8 + 32'h002C + 32'h0011
           + {16'h0, ulen} + 32'h1234 + {16'h0, dport} + {16'h0, ulen};
        for (int i = 0; i < pay.size(); i++)
            s += (i % 2 == 0) ? {16'h0, pay[i], 8'h00}
                              : {24'h0, pay[i]};
        s  = {16'h0, s[15:0]} + {16'h0, s[31:16]};
        s  = {16'h0, s[15:0]} + {16'h0, s[31:16]};
        cs = zero_cs ? 16'h0000 : ~s[15:0];
        h = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
              8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02,
              8'h08, 8'h00, 8'h45, 8'h00, tl[15:8], tl[7:0],
              8'h00, 8'h00, 8'h00, 8'h00, 8'h40, 8'h11,
              8'h00, 8'h00, 8'hC0, 8'hA8, 8'h00, 8'h01,
              8'hC0, 8'hA8, 8'h00, 8'h2C, 8'h12, 8'h34,
              dport[15:8], dport[7:0], ulen[15:8], ulen[7:0],
              cs[15:8], cs[7:0]};
        frm = {};
        for (int i = 0; i < 42; i++) frm.push_back(h[i]);
        for (int i = 0; i < pay.size(); i++) frm.push_back(pay[i]);
        for (int i = 0; i < pad; i++) frm.push_back(8'h00);
        if (flip >= 0 && !flip_late) frm[42 + flip] ^= 8'h01;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < frm.size(); i++) c = crc32(c, frm[i]);
        c = ~c;
        for (int i = 0; i < 4; i++) frm.push_back(c[8*i +: 8]);
        if (flip >= 0 && flip_late) frm[42 + flip] ^= 8'h01;
        n = pay.size();
        if (emit) begin
            for (int i = 0; i < n; i++)
                exp_pl.push_back('{d: frm[42 + i], f: i == 0,
                                   l: i == n - 1});
        end
    endtask

    task automatic send(input int n, input bit with_last, input int gap);
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                while ($urandom_range(0, 99) < gap) begin
                    @(posedge clk); #1;
                    rx_valid = 1'b0;
                    rx_first = 1'b0;
                    rx_last  = 1'b0;
                    rx_data  = 8'($urandom);
                end
            end
            @(posedge clk); #1;
            rx_valid = 1'b1;
            rx_data  = frm[i];
            rx_first = (i == 0);
            rx_last  = with_last && (i == n - 1);
            if (i == n - 1) last_cyc = cyc;
        end
    endtask

    task automatic stop();
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rx_first = 1'b0;
        rx_last  = 1'b0;
    endtask

    task automatic push_st(input logic [3:0] e, input logic [3:0] m,
                           input int due);
        exp_st.push_back('{e: e, m: m, due: due});
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_st.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_st.size() != 0) begin
            checks++;
            $display("FAIL timeout: %0d status pending, required 0",
                     exp_st.size());
            exp_st.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic ref_payload();
        pay = {};
        for (int i = 0; i < 16; i++) pay.push_back(8'h00);
        pay.push_back(8'h57);
        pay.push_back(8'h00);
    endtask

    task automatic test_reset();
        clear_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({pl_data, pl_valid, pl_first, pl_last, frame_done,
             fcs_ok, hdr_ok, udp_ok, len_err} !== 16'h0)
            $display("FAIL reset_outputs: got %h %b%b%b %b%b%b%b%b, required all 0",
                     pl_data, pl_valid, pl_first, pl_last, frame_done,
                     fcs_ok, hdr_ok, udp_ok, len_err);
        else
            passed++;
        @(posedge clk); #1;
        clear_n = 1'b1;
    endtask

    task automatic test_reference();
        int b0, d0;
        b0 = beat_cnt;
        d0 = done_cnt;
        ref_payload();
        build(16'h0400, 16'h001A, 0, 1'b0, -1, 1'b0, 1'b1);
        checks++;
        if (frm.size() !== 64)
            $display("FAIL ref_len: got %0d bytes, required 64", frm.size());
        else
            passed++;
        send(frm.size(), 1'b1, 0);
        push_st(4'b1110, 4'b1111, last_cyc + 3);
        stop();
        wait_done();
        checks++;
        if (beat_cnt - b0 !== 18)
            $display("FAIL ref_beats: got %0d, required 18", beat_cnt - b0);
        else
            passed++;
        checks++;
        if (done_cnt - d0 !== 1)
            $display("FAIL ref_done: got %0d, required 1", done_cnt - d0);
        else
            passed++;
    endtask

    task automatic test_flip();
        ref_payload();
        build(16'h0400, 16'h001A, 0, 1'b0, 5, 1'b0, 1'b1);
        send(frm.size(), 1'b1, 0);
        push_st({1'b1, 1'b1, !CSUM, 1'b0}, 4'b1111, last_cyc + 3);
        stop();
        wait_done();
        ref_payload();
        build(16'h0400, 16'h001A, 0, 1'b0, 5, 1'b1, 1'b1);
        send(frm.size(), 1'b1, 0);
        push_st({1'b0, 1'b1, !CSUM, 1'b0}, 4'b1111, last_cyc + 3);
        stop();
        wait_done();
        checks++;
        if (exp_pl.size() !== 0)
            $display("FAIL flip_beats: got %0d pending, required 0",
                     exp_pl.size());
        else
            passed++;
    endtask

    task automatic test_csum_zero();
        pay = {};
        for (int i = 0; i < 20; i++) pay.push_back(8'($urandom));
        build(16'h0400, 16'd28, 0, 1'b1, -1, 1'b0, 1'b1);
        send(frm.size(), 1'b1, 20);
        push_st(4'b1110, 4'b1111, last_cyc + 3);
        stop();
        wait_done();
    endtask

    task automatic test_bad_port();
        int b0;
        b0 = beat_cnt;
        ref_payload();
        build(16'h0401, 16'h001A, 0, 1'b0, -1, 1'b0, 1'b0);
        send(frm.size(), 1'b1, 0);
        push_st(4'b1000, 4'b1101, last_cyc + 3);
        stop();
        wait_done();
        checks++;
        if (beat_cnt - b0 !== 0)
            $display("FAIL port_beats: got %0d, required 0", beat_cnt - b0);
        else
            passed++;
    endtask

    task automatic test_short_udp();
        int b0;
        b0 = beat_cnt;
        pay = {};
        pay.push_back(8'hAB);
        pay.push_back(8'hCD);
        build(16'h0400, 16'h000A, 16, 1'b0, -1, 1'b0, 1'b1);
        send(frm.size(), 1'b1, 0);
        push_st(4'b1110, 4'b1111, last_cyc + 3);
        stop();
        wait_done();
        checks++;
        if (beat_cnt - b0 !== 2)
            $display("FAIL short_beats: got %0d, required 2", beat_cnt - b0);
        else
            passed++;
    endtask

    task automatic test_truncated();
        ref_payload();
        build(16'h0400, 16'h001A, 0, 1'b0, -1, 1'b0, 1'b0);
        send(31, 1'b1, 0);
        push_st(4'b0001, 4'b0001, last_cyc + 3);
        stop();
        wait_done();
    endtask

    task automatic test_abort();
        ref_payload();
        build(16'h0400, 16'h001A, 0, 1'b0, -1, 1'b0, 1'b0);
        send(25, 1'b0, 0);
        push_st(4'b0001, 4'b0001, 0);
        ref_payload();
        build(16'h0400, 16'h001A, 0, 1'b0, -1, 1'b0, 1'b1);
        send(frm.size(), 1'b1, 0);
        push_st(4'b1110, 4'b1111, last_cyc + 3);
        stop();
        wait_done();
    endtask

    task automatic test_reset_mid();
        int d0;
        ref_payload();
        build(16'h0400, 16'h001A, 0, 1'b0, -1, 1'b0, 1'b0);
        send(20, 1'b0, 0);
        stop();
        clear_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        clear_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({frame_done, fcs_ok, hdr_ok, udp_ok, len_err, pl_valid} !== 6'h0)
            $display("FAIL midreset_flags: got %b%b%b%b%b%b, required 000000",
                     frame_done, fcs_ok, hdr_ok, udp_ok, len_err, pl_valid);
        else
            passed++;
        d0 = done_cnt;
        ref_payload();
        build(16'h0400, 16'h001A, 0, 1'b0, -1, 1'b0, 1'b1);
        send(frm.size(), 1'b1, 0);
        push_st(4'b1110, 4'b1111, last_cyc + 3);
        stop();
        wait_done();
        checks++;
        if (done_cnt - d0 !== 1)
            $display("FAIL midreset_done: got %0d, required 1", done_cnt - d0);
        else
            passed++;
    endtask

    task automatic test_back_to_back();
        int b0, d0;
        b0 = beat_cnt;
        d0 = done_cnt;
        ref_payload();
        build(16'h0400, 16'h001A, 0, 1'b0, -1, 1'b0, 1'b1);
        send(frm.size(), 1'b1, 30);
        push_st(4'b1110, 4'b1111, last_cyc + 3);
        pay = {};
        pay.push_back(8'hAB);
        pay.push_back(8'hCD);
        build(16'h0400, 16'h000A, 16, 1'b0, -1, 1'b0, 1'b1);
        send(frm.size(), 1'b1, 30);
        push_st(4'b1110, 4'b1111, last_cyc + 3);
        stop();
        wait_done();
        checks++;
        if (beat_cnt - b0 !== 20 || done_cnt - d0 !== 2)
            $display("FAIL b2b_counts: got beats=%0d done=%0d, required 20 and 2",
                     beat_cnt - b0, done_cnt - d0);
        else
            passed++;
    endtask

    initial begin
        test_reset();
        test_reference();
        test_flip();
        test_csum_zero();
        test_bad_port();
        test_short_udp();
        test_truncated();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (exp_pl.size() !== 0 || exp_st.size() !== 0)
            $display("FAIL leftover: got %0d beats %0d status pending, required 0",
                     exp_pl.size(), exp_st.size());
        else
            passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/eth_udp_rx_check.md
# eth_udp_rx_check

Receive-side counterpart of the Ethernet/UDP transmit path: it consumes a received frame byte stream (preamble/SFD already stripped, FCS still attached) and parses the fixed Ethernet II / IPv4 / UDP header. It checks the frame CRC32 (FCS), the destination addressing and the UDP checksum, and streams the UDP payload bytes out. After the last byte it reports a one-cycle status so downstream logic can commit or discard the payload it has already received.

## Interface
Parameters:
- LOCAL_IP, 32'hC0A8_002C, IPv4 destination address accepted (192.168.0.44)
- LOCAL_PORT, 16'h0400, UDP destination port accepted

Ports:
- clk  in  1  sole clock
- clear_n  in  1  reset; synchronous and active-low
- rx_data  in  8  received byte
- rx_valid  in  1  rx_data valid this cycle; gaps allowed
- rx_first  in  1  qualifies rx_valid; byte 0 of a frame
- rx_last  in  1  qualifies rx_valid; last FCS byte
- pl_data  out  8  UDP payload byte
- pl_valid  out  1  pl_data valid; no backpressure
- pl_first  out  1  first payload byte
- pl_last  out  1  last payload byte, or truncation point
- frame_done  out  1  one-cycle status strobe
- fcs_ok  out  1  CRC residue correct; valid with frame_done
- hdr_ok  out  1  header fields match; valid with frame_done
- udp_ok  out  1  UDP checksum correct; valid with frame_done
- len_err  out  1  truncated or inconsistent frame; valid with frame_done

## Operation
- Byte offsets: ethertype 12–13, ver/IHL 14, protocol 23, src IP 26–29, dst IP 30–33, dst port 36–37, UDP length 38–39, UDP checksum 40–41, payload starts at 42.
- hdr_ok = ethertype 0x0800 & byte14 0x45 & protocol 0x11 & dst IP == LOCAL_IP & dst port == LOCAL_PORT.
- Payload bytes: 42 .. 42+(UDP length−8)−1. Bytes after the payload and before rx_last are pad or FCS. They are not emitted and not summed.
- CRC: reflected CRC32 (polynomial 0xEDB88320).
  - Register is initialised to 0xFFFFFFFF on the rx_first byte.
  - It is updated with every byte, including the FCS bytes.
  - fcs_ok = register == 0xDEBB20E3 after the rx_last byte.
- UDP checksum: one's-complement sum over:
  - the pseudo-header: src IP, dst IP, 0x0011, UDP length;
  - UDP bytes 34–41;
  - the payload, with an odd final byte padded low with 0x00.
- Checksum arithmetic: 32-bit accumulator; the fold (upper16 + lower16) is applied twice at the end.
- udp_ok = folded sum == 0xFFFF, or checksum field == 0x0000.
- States:
  - IDLE: wait for rx_first.
  - HDR: bytes 0–41.
  - DATA: payload.
  - TAIL: pad and FCS until rx_last.
  - DROP: consume until rx_last; no pl_valid.
- Transitions:
  - HDR→DROP at byte 42 if hdr_ok=0 or UDP length < 8 (len_err=1 in the latter case).
  - HDR→DATA, or HDR→TAIL if the payload length is 0.
  - DATA→TAIL after the last payload byte.
  - Any state → IDLE after rx_last.
- pl_valid is asserted only in DATA for frames with hdr_ok=1.
- len_err=1 if any of these hold:
  - rx_last arrives in HDR or DATA;
  - fewer than 4 bytes follow the payload;
  - total frame length < 64.
- rx_last in DATA: that byte is emitted with pl_last=1.
- rx_first in a non-IDLE state (missing rx_last): abort the current frame. Emit frame_done with len_err=1 and restart on that byte as byte 0.

## Timing
- Reset: all outputs 0, state IDLE. Reset mid-frame discards the frame with no frame_done; the block resumes at the next rx_first.
- Payload latency: pl_* are registered, 1 cycle after the accepting edge.
- Status latency: frame_done is asserted exactly 2 cycles after the edge accepting rx_last (one cycle accumulate, one cycle fold/compare). Status outputs are held until the next frame_done.
- Back-to-back: rx_first may arrive the cycle after rx_last. The CRC and sum are snapshotted into status registers, so the new frame's accumulation is independent.
- rx_valid=0: all counters and accumulators hold.

## Configuration
- RX_UDP_CSUM_EN defined: UDP checksum accumulator and compare are built; udp_ok is as specified above.
- RX_UDP_CSUM_EN undefined: checksum logic is compiled out; udp_ok is constant 1 whenever frame_done is asserted.

## Test plan
- Reference frame: 192.168.0.44:0x0400, UDP length 0x001A, payload 16×0x00, then 0x57,0x00, then correct FCS, 64 bytes total. Required: 18 pl_valid beats with pl_first on beat 1 and pl_last on beat 18; then frame_done with fcs_ok=1, hdr_ok=1, udp_ok=1, len_err=0.
- Same frame with payload byte 5 flipped to 0x01 and FCS recomputed -> fcs_ok=1, udp_ok=0. Same flip without recomputing FCS -> fcs_ok=0.
- UDP checksum field 0x0000 with an arbitrary payload -> udp_ok=1.
- dst port 0x0401 -> no pl_valid, frame_done with hdr_ok=0.
- UDP length 0x000A (2-byte payload 0xAB,0xCD) plus 16 pad bytes -> 2 payload beats, fcs_ok=1, udp_ok=1, len_err=0.
- rx_last at byte 30 -> frame_done 2 cycles later with len_err=1.
- clear_n low mid-frame, then a full valid frame -> exactly one frame_done, with all status flags good.
